// File: rtl/instr_buff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_buff_pkg                                               |
// | Description : Shared types and constants for the instruction buffer        |
// |               sequencer (state encoding, pointer width helper, counter     |
// |               widths).                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package instr_buff_pkg;

   // Sequencer states: normal operation, or draining after a redirect
   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam int PERF_CNT_W  = 32;
   localparam int FLUSH_CNT_W = 4;

   // Index bits plus one wrap bit, so full and empty are distinguishable
   function automatic int PTR_W(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_buff_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_buff_ram                                               |
// | Description : DEPTH x DATA_WIDTH storage, one synchronous write port and   |
// |               one asynchronous read port. Contents are not reset.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_buff_ram
   import instr_buff_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Write port: store the accepted word at the tail slot
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Head word is presented combinationally to the decode side
   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/instr_buff_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_buff_ctrl                                              |
// | Description : Fetch-to-decode instruction buffer sequencer. Circular queue |
// |               with wrap-bit pointers, epoch-based stale-fetch discard and  |
// |               a RUN/FLUSH reload state machine.                            |
// |               Optional perf counters: define INSTR_BUFF_PERF_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_buff_ctrl
   import instr_buff_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 8,
   parameter int EPOCH_W      = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [EPOCH_W-1:0]    in_epoch,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  reload,
   output logic [EPOCH_W-1:0]    cur_epoch,
   output logic [7:0]            head,
   output logic [7:0]            tail,
   output logic [7:0]            full,
   output logic [7:0]            reload_o,
   output logic [PERF_CNT_W-1:0] perf_full_cyc,
   output logic [PERF_CNT_W-1:0] perf_reloads,
   output logic [PERF_CNT_W-1:0] perf_stale
);

   localparam int C_PTR_W = PTR_W(DEPTH);
   localparam int C_AW    = C_PTR_W - 1;
   localparam logic [FLUSH_CNT_W-1:0] C_FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   logic [C_PTR_W-1:0]     r_head, r_tail;
   logic [EPOCH_W-1:0]     r_epoch;
   logic                   r_reload_q;
   state_t                 r_state, w_state_nxt;
   logic [FLUSH_CNT_W-1:0] r_flush_cnt, w_flush_cnt_nxt;

   logic w_empty, w_full, w_run, w_epoch_ok, w_stale, w_push, w_pop;

   assign w_empty    = (r_head == r_tail);
   assign w_full     = (r_head[C_AW-1:0] == r_tail[C_AW-1:0]) && (r_head[C_AW] != r_tail[C_AW]);
   assign w_run      = (r_state == ST_RUN);
   assign w_epoch_ok = (in_epoch == r_epoch);
   assign w_stale    = in_valid && !w_epoch_ok;

   // Stale words are always swallowed so fetch never stalls on them; a reload wins over everything
   assign in_ready  = !reload && (w_stale || (w_run && !w_full && w_epoch_ok));
   assign w_push    = in_valid && w_epoch_ok && w_run && !w_full && !reload;
   assign out_valid = w_run && !w_empty;
   assign w_pop     = out_valid && out_ready && !reload;

   assign cur_epoch = r_epoch;
   assign head      = 8'(r_head[C_AW-1:0]);
   assign tail      = 8'(r_tail[C_AW-1:0]);
   assign full      = {7'd0, w_full};
   assign reload_o  = {7'd0, r_reload_q};

   instr_buff_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (C_AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_tail[C_AW-1:0]),
      .i_wdata (in_data),
      .i_raddr (r_head[C_AW-1:0]),
      .o_rdata (out_data)
   );

   // State register for the reload sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   // Next state: reload (re)starts FLUSH; FLUSH counts down to zero then resumes RUN
   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      if (reload) begin
         w_state_nxt     = ST_FLUSH;
         w_flush_cnt_nxt = C_FLUSH_INIT;
      end else if (r_state == ST_FLUSH) begin
         if (r_flush_cnt == '0) begin
            w_state_nxt = ST_RUN;
         end else begin
            w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
         end
      end
   end

   // Queue pointers, epoch and the one-cycle reload indication
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_epoch    <= '0;
         r_reload_q <= 1'b0;
      end else begin
         r_reload_q <= reload;
         if (reload) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_epoch <= r_epoch + EPOCH_W'(1);
         end else begin
            if (w_push) r_tail <= r_tail + C_PTR_W'(1);
            if (w_pop)  r_head <= r_head + C_PTR_W'(1);
         end
      end
   end

`ifdef INSTR_BUFF_PERF_EN
   logic [PERF_CNT_W-1:0] r_perf_full, r_perf_rel, r_perf_stale;

   // Saturating event counters, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_full  <= '0;
         r_perf_rel   <= '0;
         r_perf_stale <= '0;
      end else begin
         if (w_full && (r_perf_full != '1))             r_perf_full  <= r_perf_full + PERF_CNT_W'(1);
         if (reload && (r_perf_rel != '1))              r_perf_rel   <= r_perf_rel + PERF_CNT_W'(1);
         if (w_stale && !reload && (r_perf_stale != '1)) r_perf_stale <= r_perf_stale + PERF_CNT_W'(1);
      end
   end

   assign perf_full_cyc = r_perf_full;
   assign perf_reloads  = r_perf_rel;
   assign perf_stale    = r_perf_stale;
`else
   assign perf_full_cyc = '0;
   assign perf_reloads  = '0;
   assign perf_stale    = '0;
`endif

endmodule
`default_nettype wire
